alu_pipe: RTL

- Parametrised, registered successor to the 4-bit combinational ALU.
- Adds valid/ready handshakes on input and output, a 3-bit opcode (XOR, SUB, shifts, multi-cycle MUL), and status flags.
- Sits between an operand source (sequencer or register file) and a result sink that may apply backpressure.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flag bit positions inside flags_t (MSB first: carry, ovf, zero).
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 2;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is asserted during the last step; product then shows the final sum
// that the step is about to commit, so the caller can capture it on that edge.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;
    logic               run;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign product  = acc_next;
    assign done     = run && (cnt == CW'(1));

    // Operand latch on start, then one add-and-shift step per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1))
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and a
// multi-cycle multiplier. One operation in flight; results held until taken.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               state;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    flags_t               alu_flg;
    logic                 shift_oor;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    // Only the state decides readiness, so no input-to-output comb path.
    assign in_ready  = (state == ST_IDLE);
    assign mul_start = (state == ST_IDLE) && in_valid && (op == OP_MUL);

    assign sum       = {1'b0, a} + {1'b0, b};
    // Whole b is compared so large shift amounts are not aliased by truncation.
    assign shift_oor = (b >= WIDTH'(WIDTH));

    // Single-cycle datapath for everything except MUL.
    always_comb begin
        alu_res = '0;
        alu_flg = '0;
        case (op)
            OP_ADD: begin
                alu_res       = sum[WIDTH-1:0];
                alu_flg.carry = sum[WIDTH];
                alu_flg.ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SUB: begin
                alu_res       = a - b;
                alu_flg.carry = (a < b);
                alu_flg.ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: alu_res = shift_oor ? '0 : (a << b[SHW-1:0]);
            OP_SHR: alu_res = shift_oor ? '0 : (a >> b[SHW-1:0]);
            OP_MUL: alu_res = '0;
        endcase
        alu_flg.zero = (alu_res == '0);
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Control FSM with registered result, flags, out_valid and busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            state <= ST_MUL;
                            busy  <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            carry     <= alu_flg.carry;
                            ovf       <= alu_flg.ovf;
                            zero      <= alu_flg.zero;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= mul_prod[WIDTH-1:0];
                        carry     <= |mul_prod[2*WIDTH-1:WIDTH];
                        ovf       <= 1'b0;
                        zero      <= (mul_prod[WIDTH-1:0] == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
